la_axis_arbiter: RTL

Packet-granular arbiter that shares the single upstream AXI-Stream port between the logic-analyzer trace stream (requester 0, with high-priority request) and a second user-project stream (requester 1). It sits between the trace FIFO output and the upstream AXIS switch. Grants are held for a whole packet, and a burst limit bounds how long one requester can hold the port. Output data passes through one registered slice.

---
 rtl/la_arb_pkg.sv | 46 ++++
 rtl/axis_reg_slice.sv | 29 ++
 rtl/la_axis_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/la_arb_pkg.sv
// Shared types and helpers for the LA / user-project AXIS arbiter.
package la_arb_pkg;

  localparam int MAX_BURST_DEF = 16;
  localparam int DATA_W_DEF    = 32;
  localparam int USER_W        = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]   data;
    logic [DATA_W_DEF/8-1:0] strb;
    logic [DATA_W_DEF/8-1:0] keep;
    logic [USER_W-1:0]       user;
    logic                    last;
  } axis_beat_t;

  // High-priority LA request wins outright; otherwise prefer whoever was not served last.
  function automatic arb_state_e arb_pick(input logic hpri, input logic v0,
                                          input logic v1, input logic last_grant);
    arb_state_e pick;
    pick = IDLE;
    if (hpri && v0)     pick = GNT0;
    else if (v0 && v1)  pick = last_grant ? GNT0 : GNT1;
    else if (v0)        pick = GNT0;
    else if (v1)        pick = GNT1;
    return pick;
  endfunction

  function automatic logic [1:0] grant_of(input arb_state_e s);
    case (s)
      GNT0:    return GRANT_S0;
      GNT1:    return GRANT_S1;
      default: return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXIS output register; accepts a new beat when empty or draining this cycle.
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  assign s_ready = !m_valid | m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (s_valid & s_ready) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/la_axis_arbiter.sv
// Packet-granular two-way AXIS arbiter (LA trace vs user stream) with burst limit.
//   state | meaning
//   IDLE  | no grant; arbitrate among valid requesters
//   GNT0  | LA trace stream owns the upstream port
//   GNT1  | user stream owns the upstream port
module la_axis_arbiter
  import la_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                axis_clk,
  input  logic                axis_rst,
  input  logic [DATA_W-1:0]   s0_tdata,
  input  logic [DATA_W/8-1:0] s0_tstrb,
  input  logic [DATA_W/8-1:0] s0_tkeep,
  input  logic [1:0]          s0_tuser,
  input  logic                s0_tlast,
  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic                s0_hpri_req,
  input  logic [DATA_W-1:0]   s1_tdata,
  input  logic [DATA_W/8-1:0] s1_tstrb,
  input  logic [DATA_W/8-1:0] s1_tkeep,
  input  logic [1:0]          s1_tuser,
  input  logic                s1_tlast,
  input  logic                s1_tvalid,
  output logic                s1_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tstrb,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic [1:0]          m_tuser,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [1:0]          arb_grant,
  output logic                arb_trunc
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic [STRB_W-1:0] keep;
    logic [USER_W-1:0] user;
    logic              last;
  } beat_t;

  arb_state_e state;
  arb_state_e idle_pick;
  logic       last_grant;
  logic [7:0] beat_cnt;
  logic [1:0] grant_q;
  logic       trunc_q;
  logic       slice_ready;
  logic       acc;
  logic       sel_last;
  logic       eff_last;
  beat_t      sel_beat;
  beat_t      out_beat;

  assign s0_tready = (state == GNT0) & slice_ready;
  assign s1_tready = (state == GNT1) & slice_ready;
  assign acc       = (s0_tvalid & s0_tready) | (s1_tvalid & s1_tready);
  assign sel_last  = (state == GNT1) ? s1_tlast : s0_tlast;
  assign eff_last  = sel_last | (beat_cnt == CNT_LAST);
  assign idle_pick = arb_pick(s0_hpri_req, s0_tvalid, s1_tvalid, last_grant);

  always_comb begin
    if (state == GNT1)
      sel_beat = '{data: s1_tdata, strb: s1_tstrb, keep: s1_tkeep, user: s1_tuser, last: eff_last};
    else
      sel_beat = '{data: s0_tdata, strb: s0_tstrb, keep: s0_tkeep, user: s0_tuser, last: eff_last};
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      grant_q    <= GRANT_NONE;
      trunc_q    <= 1'b0;
    end else begin
      // Truncation is a forced last on a beat the source did not mark as last.
      trunc_q <= acc & eff_last & !sel_last;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          state    <= idle_pick;
          grant_q  <= grant_of(idle_pick);
        end
        GNT0, GNT1: begin
          if (acc) begin
            if (eff_last) begin
              state      <= IDLE;
              grant_q    <= GRANT_NONE;
              last_grant <= (state == GNT1);
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= GRANT_NONE;
        end
      endcase
    end
  end

  axis_reg_slice #(.W($bits(beat_t))) u_slice (
    .clk     (axis_clk),
    .rst     (axis_rst),
    .s_data  (sel_beat),
    .s_valid (acc),
    .s_ready (slice_ready),
    .m_data  (out_beat),
    .m_valid (m_tvalid),
    .m_ready (m_tready)
  );

  assign m_tdata   = out_beat.data;
  assign m_tstrb   = out_beat.strb;
  assign m_tkeep   = out_beat.keep;
  assign m_tuser   = out_beat.user;
  assign m_tlast   = out_beat.last;
  assign arb_grant = grant_q;
  assign arb_trunc = trunc_q;

endmodule
